// File: rtl/core_imem_responder.sv
// Instruction-fetch responder: serves word fetches from an internal array after a fixed
// wait-state count, flags misaligned/out-of-window fetches, and has a backdoor load port.
module core_imem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imem_valid,
  output logic                     imem_ready,
  input  logic [31:0]              imem_addr,
  output logic [31:0]              imem_rdata,
  output logic                     imem_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_wdata
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = 4;
  localparam logic [32:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        fetch_addr;
  logic [32:0]        fetch_off;
  logic               fetch_bad;
  logic [IDX_W-1:0]   fetch_idx;
  logic               enter_resp;

  logic [31:0]        mem [DEPTH];

  // Live address while idle (covers LATENCY=1), latched address afterwards.
  // Offset below the base wraps to a huge 33-bit value, so one compare covers both bounds.
  always_comb begin
    fetch_addr = (state == IDLE) ? imem_addr : addr_q;
    fetch_off  = {1'b0, fetch_addr} - WIN_LO;
    fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_off >= WIN_SPAN);
    fetch_idx  = fetch_off[IDX_W+1:2];
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    case (state)
      IDLE: begin
        if (imem_valid) begin
          addr_d = imem_addr;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!imem_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      imem_ready <= 1'b0;
      imem_err   <= 1'b0;
      imem_rdata <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      addr_q     <= addr_d;
      imem_ready <= enter_resp;
      imem_err   <= enter_resp && fetch_bad;
      imem_rdata <= (enter_resp && !fetch_bad) ? mem[fetch_idx] : '0;
    end
  end

  // Backdoor load; a same-edge read of the same word sees the old contents.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_wdata;
  end

endmodule
